// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the fetch path:
//   XLEN       - default data / PC width
//   RESET_PC   - default fetch address after reset
//   fq_entry_t - one prefetch-queue entry {pc, inst} at the default XLEN
//   fq_pack    - helper that builds an fq_entry_t from its two fields
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fq_entry_t;

    function automatic fq_entry_t fq_pack(input logic [XLEN-1:0] pc,
                                          input logic [31:0]     inst);
        fq_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Bus bundle of the fetch unit: the instruction-RAM read port and the
// valid/ready handshake towards decode.
//   imem_addr  - word address presented to the instruction RAM
//   imem_rdata - combinational read data for imem_addr
//   out_valid  - head entry valid
//   out_ready  - decode accepts the head entry
//   out_pc     - PC of the head entry
//   out_inst   - instruction of the head entry
// Modport master = fetch unit, slave = RAM/decode side.
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IM_AW = 10
);

    logic [IM_AW-1:0] imem_addr;
    logic [31:0]      imem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_inst;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst
    );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with register storage, combinational head read and a
// synchronous flush that empties the queue in one cycle.
//   clk, rstn - clock, asynchronous active-low reset (clears storage too)
//   flush_i   - drop all entries, pointers/count to 0 (wins over push/pop)
//   push_i    - write wdata_i (caller guarantees space or same-cycle pop)
//   pop_i     - retire head entry (caller guarantees not empty)
//   rdata_o   - head entry
//   count_o   - occupied entries; full_o / empty_o derived from it
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = {PW{1'b0}};
            rptr_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_i) begin
                wptr_d = wptr_q + PW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_i) begin
                rptr_d = rptr_q + PW'(1);
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_i && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch unit: owns the fetch PC, reads one word per cycle from
// an asynchronous-read instruction RAM and buffers {pc, inst} pairs in a
// DEPTH-entry prefetch FIFO that feeds decode over valid/ready.
//   clk, rstn   - clock, asynchronous active-low reset
//   fetch_en    - fetch permitted (low holds fetch_pc, queue still drains)
//   redirect    - flush queue and restart fetch at redirect_pc
//   redirect_pc - new fetch address, low two bits ignored
//   bus         - imem read port + decode handshake (fetch_queue_if.master)
//   fetch_pc    - current fetch PC
//   count       - occupied queue entries
// ---------------------------------------------------------------------------
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = cpu_pkg::XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     IM_AW    = 10,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC),
    localparam int unsigned    CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fetch_en,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    fetch_queue_if.master    bus,
    output logic [XLEN-1:0]  fetch_pc,
    output logic [CW-1:0]    count
);

    // Same layout as cpu_pkg::fq_entry_t, but sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;
    logic [CW-1:0]   count_s;
    entry_t          wentry_s;
    entry_t          rentry_s;
    logic [EW-1:0]   rdata_s;

    // Redirect squashes any same-cycle handshake; a full queue may still push when the head leaves.
    always_comb begin
        pop_s  = ~empty_s & bus.out_ready & ~redirect;
        push_s = fetch_en & ~redirect & (~full_s | pop_s);
    end

    // Fetch PC next-state: redirect wins, otherwise advance one word per push.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push_s) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Pair the current fetch PC with the RAM word it addresses.
    always_comb begin
        wentry_s.pc   = fetch_pc_q;
        wentry_s.inst = bus.imem_rdata;
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (redirect),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (wentry_s),
        .rdata_o (rdata_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign rentry_s      = entry_t'(rdata_s);
    assign bus.imem_addr = fetch_pc_q[IM_AW+1:2];
    assign bus.out_valid = ~empty_s;
    assign bus.out_pc    = rentry_s.pc;
    assign bus.out_inst  = rentry_s.inst;
    assign fetch_pc      = fetch_pc_q;
    assign count         = count_s;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    // Reference model: list of PCs held in the queue plus the fetch PC.
    logic [31:0] exp_q[$];
    logic [31:0] exp_fpc;

    fetch_queue_if #(.XLEN(32), .IM_AW(10)) bus ();

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .IM_AW(10), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .fetch_pc    (fetch_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Instruction RAM: each word encodes its own word index.
    assign bus.imem_rdata = 32'h5A00_0000 | {22'd0, bus.imem_addr};

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h5A00_0000 | {22'd0, pc[11:2]};
    endfunction

    // One clock: advance DUT and model from the current inputs; returns at the next negedge.
    task automatic tick();
        bit do_pop, do_push;
        fq_entry_t e;
        do_pop  = (exp_q.size() != 0) && bus.out_ready && !redirect;
        do_push = fetch_en && !redirect && ((exp_q.size() < DEPTH) || do_pop);
        @(posedge clk);
        if (redirect) begin
            exp_q.delete();
            exp_fpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (do_pop) e.pc = exp_q.pop_front();
            if (do_push) begin
                exp_q.push_back(exp_fpc);
                exp_fpc = exp_fpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (fetch_pc !== RPC) begin errors++; $display("FAIL reset_fetch_pc got=%h exp=%h", fetch_pc, RPC); end
        checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL reset_imem_addr got=%h exp=0", bus.imem_addr); end
        checks++; if (bus.out_pc !== 32'd0 || bus.out_inst !== 32'd0) begin errors++; $display("FAIL reset_storage got=%h/%h exp=0/0", bus.out_pc, bus.out_inst); end
        exp_q.delete(); exp_fpc = RPC;
        rstn = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC + 32'(4 * i)) begin
                errors++; $display("FAIL stream_pc[%0d] got=%0b/%h exp=1/%h", i, bus.out_valid, bus.out_pc, RPC + 32'(4 * i)); end
            checks++; if (bus.out_inst !== inst_of(RPC + 32'(4 * i)) || count !== 3'd1) begin
                errors++; $display("FAIL stream_inst[%0d] got=%h cnt=%0d exp=%h cnt=1", i, bus.out_inst, count, inst_of(RPC + 32'(4 * i))); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] head, last;
        head = bus.out_pc;
        bus.out_ready = 1'b0;
        repeat (10) tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count got=%0d exp=4", count); end
        checks++; if (bus.out_pc !== head) begin errors++; $display("FAIL bp_head got=%h exp=%h", bus.out_pc, head); end
        checks++; if (fetch_pc !== head + 32'd16) begin errors++; $display("FAIL bp_fetch_pc got=%h exp=%h", fetch_pc, head + 32'd16); end
        // Full queue draining with continuous ready: one per cycle, nothing lost.
        bus.out_ready = 1'b1;
        last = head - 32'd4;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== last + 32'd4 || count !== 3'd4) begin
                errors++; $display("FAIL full_tput[%0d] got=%0b/%h cnt=%0d exp=1/%h cnt=4", i, bus.out_valid, bus.out_pc, count, last + 32'd4); end
            last = last + 32'd4;
            tick();
        end
    endtask

    task automatic test_redirect();
        fetch_en = 1'b0; tick(); fetch_en = 1'b1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL redir_pre_count got=%0d exp=3", count); end
        redirect = 1'b1; redirect_pc = 32'h1c00_0103;
        tick();
        redirect = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL redir_flush got=%0b/%0d exp=0/0", bus.out_valid, count); end
        checks++; if (fetch_pc !== 32'h1c00_0100) begin errors++; $display("FAIL redir_fetch_pc got=%h exp=1c000100", fetch_pc); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1c00_0100) begin errors++; $display("FAIL redir_first got=%0b/%h exp=1/1c000100", bus.out_valid, bus.out_pc); end
        tick();
        checks++; if (bus.out_pc !== 32'h1c00_0104 || bus.out_inst !== inst_of(32'h1c00_0104)) begin errors++; $display("FAIL redir_second got=%h/%h exp=1c000104", bus.out_pc, bus.out_inst); end
    endtask

    task automatic test_fetch_en();
        logic [31:0] frozen;
        fetch_en = 1'b0;
        tick();
        frozen = fetch_pc;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (fetch_pc !== frozen) begin errors++; $display("FAIL halt_frozen[%0d] got=%h exp=%h", i, fetch_pc, frozen); end
        end
        checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL halt_drain got=%0d/%0b exp=0/0", count, bus.out_valid); end
        fetch_en = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== frozen) begin errors++; $display("FAIL halt_resume0 got=%0b/%h exp=1/%h", bus.out_valid, bus.out_pc, frozen); end
        tick();
        checks++; if (bus.out_pc !== frozen + 32'd4) begin errors++; $display("FAIL halt_resume1 got=%h exp=%h", bus.out_pc, frozen + 32'd4); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.out_pc !== 32'hFFFF_FFF8 + 32'(4 * i) || bus.out_inst !== inst_of(32'hFFFF_FFF8 + 32'(4 * i))) begin
                errors++; $display("FAIL wrap[%0d] got=%h/%h exp=%h", i, bus.out_pc, bus.out_inst, 32'hFFFF_FFF8 + 32'(4 * i)); end
        end
    endtask

    task automatic test_async_reset();
        fetch_en = 1'b0; tick(); tick();
        fetch_en = 1'b1; bus.out_ready = 1'b0; tick(); tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL arst_pre_count got=%0d exp=2", count); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL arst_immediate got=%0b/%0d exp=0/0", bus.out_valid, count); end
        checks++; if (fetch_pc !== RPC) begin errors++; $display("FAIL arst_fetch_pc got=%h exp=%h", fetch_pc, RPC); end
        exp_q.delete(); exp_fpc = RPC;
        @(negedge clk);
        rstn = 1'b1; bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC) begin errors++; $display("FAIL arst_restart got=%0b/%h exp=1/%h", bus.out_valid, bus.out_pc, RPC); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            fetch_en      = ($urandom_range(0, 7) != 0);
            redirect      = ($urandom_range(0, 19) == 0);
            redirect_pc   = $urandom;
            tick();
            checks++; if (bus.out_valid !== (exp_q.size() != 0) || count !== 3'(exp_q.size())) begin
                errors++; $display("FAIL rand_occ[%0d] got=%0b/%0d exp=%0d entries", i, bus.out_valid, count, exp_q.size()); end
            checks++; if (fetch_pc !== exp_fpc || bus.imem_addr !== exp_fpc[11:2]) begin
                errors++; $display("FAIL rand_fetch_pc[%0d] got=%h exp=%h", i, fetch_pc, exp_fpc); end
            if (exp_q.size() != 0) begin
                checks++; if (bus.out_pc !== exp_q[0] || bus.out_inst !== inst_of(exp_q[0])) begin
                    errors++; $display("FAIL rand_head[%0d] got=%h/%h exp=%h/%h", i, bus.out_pc, bus.out_inst, exp_q[0], inst_of(exp_q[0])); end
            end
        end
        redirect = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fetch_en();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
